octave_readout_sched: RTL and testbench

Readout scheduler for one unison, i.e. the NUM_OCTAVES wavelet cores (octave 0 = A7, highest). It generates a ruler-sequence strobe schedule so that exactly one octave is sampled per clk_master cycle, with octave k sampled every 2^(k+1) cycles. One cycle after each strobe it captures that octave's read_out_I/Q together with a gray-coded timestamp. Records are buffered in a FIFO and drained by the host through a valid/ready handshake.

---
 rtl/octave_readout_sched.sv | 194 +++++++++++++++++++
 tb/tb_octave_readout_sched.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/octave_readout_sched.sv
// -----------------------------------------------------------------------------
// octave_readout_sched
//
// Readout scheduler for one unison of NUM_OCTAVES wavelet cores (octave 0 is
// the highest band). A free-running schedule counter is decoded as a ruler
// sequence, so exactly one octave is strobed per active cycle and octave k is
// strobed every 2^(k+1) cycles. In the cycle after a strobe, that octave's
// I/Q pair is captured together with the gray-coded timestamp. Records whose
// octave is enabled in oct_mask are queued in a FIFO, and the host drains
// them through a valid/ready handshake.
//
// Ports
//   clk_master      : single clock
//   rstb            : asynchronous active-low reset
//   en              : schedule enable (counter advances only while high)
//   oct_mask        : bit k = 1 keeps records of octave k
//   oct_strobe      : one-hot sample strobe to the cores (registered)
//   gray_cnt        : gray code of the schedule counter (registered)
//   read_out_I_bus  : {I1,I0} of octave k at bits [2k+1:2k]
//   read_out_Q_bus  : same packing as read_out_I_bus, for Q
//   rec_valid       : FIFO non-empty
//   rec_ready       : host accepts rec_data
//   rec_data        : {oct_idx[2:0], I[1:0], Q[1:0], ts[CNT_W-1:0]}, FWFT
//   ovf             : sticky, set when a record is dropped on a full FIFO
//   ovf_clr         : clears ovf (a simultaneous drop wins)
// -----------------------------------------------------------------------------
module octave_readout_sched #(
    parameter int NUM_OCTAVES = 8,
    parameter int CNT_W       = 10,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                     clk_master,
    input  logic                     rstb,
    input  logic                     en,
    input  logic [NUM_OCTAVES-1:0]   oct_mask,
    output logic [NUM_OCTAVES-1:0]   oct_strobe,
    output logic [CNT_W-1:0]         gray_cnt,
    input  logic [2*NUM_OCTAVES-1:0] read_out_I_bus,
    input  logic [2*NUM_OCTAVES-1:0] read_out_Q_bus,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [CNT_W+6:0]         rec_data,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int REC_W = CNT_W + 7;

    // Schedule state
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_OCTAVES-1:0] strobe_q, strobe_d;
    logic [CNT_W-1:0]       gray_q, gray_d;
    logic [NUM_OCTAVES-1:0] slot_hot;

    // Capture stage: octave index and timestamp of the strobe just issued
    logic                   pend_vld_q, pend_vld_d;
    logic [2:0]             pend_idx_q, pend_idx_d;
    logic [CNT_W-1:0]       pend_ts_q, pend_ts_d;

    // FIFO state
    logic [REC_W-1:0]       fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic                   ovf_q, ovf_d;

    logic [1:0]             cap_i, cap_q;
    logic                   cap_keep;
    logic                   push_req, do_push, do_pop, fifo_full, drop;
    logic [REC_W-1:0]       rec_word;

    // Ruler decode: octave k owns the slot when cnt ends in exactly k ones.
    // When the low NUM_OCTAVES bits are all ones every bit is zero (idle slot).
    generate
        for (genvar gi = 0; gi < NUM_OCTAVES; gi++) begin : g_slot
            if (gi == 0) begin : g_lsb
                assign slot_hot[gi] = ~cnt_q[0];
            end else begin : g_upper
                assign slot_hot[gi] = ~cnt_q[gi] & (&cnt_q[gi-1:0]);
            end
        end
    endgenerate

    always_comb begin
        cnt_d    = cnt_q;
        strobe_d = '0;
        gray_d   = gray_q;
        if (en) begin
            cnt_d    = cnt_q + CNT_W'(1);
            strobe_d = slot_hot;
            gray_d   = cnt_q ^ (cnt_q >> 1);
        end
    end

    // The capture stage loads every cycle regardless of en, so a strobe
    // issued just before en falls is still captured.
    always_comb begin
        pend_vld_d = |strobe_q;
        pend_idx_d = 3'd0;
        for (int k = 0; k < NUM_OCTAVES; k++) begin
            if (strobe_q[k]) begin
                pend_idx_d = 3'(k);
            end
        end
        pend_ts_d = gray_q;
    end

    // Cores answer one cycle after the strobe: select their slice now.
    always_comb begin
        cap_i    = 2'b00;
        cap_q    = 2'b00;
        cap_keep = 1'b0;
        for (int k = 0; k < NUM_OCTAVES; k++) begin
            if (pend_idx_q == 3'(k)) begin
                cap_i    = read_out_I_bus[2*k +: 2];
                cap_q    = read_out_Q_bus[2*k +: 2];
                cap_keep = oct_mask[k];
            end
        end
    end

    assign rec_word  = {pend_idx_q, cap_i, cap_q, pend_ts_q};
    assign push_req  = pend_vld_q & cap_keep;
    assign rec_valid = (count_q != '0);
    assign fifo_full = (count_q == (AW+1)'(FIFO_DEPTH));
    assign do_pop    = rec_valid & rec_ready;
    // A full FIFO still accepts a record when a pop frees a slot in the same cycle.
    assign do_push   = push_req & (~fifo_full | do_pop);
    assign drop      = push_req & fifo_full & ~do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            cnt_q      <= '0;
            strobe_q   <= '0;
            gray_q     <= '0;
            pend_vld_q <= 1'b0;
            pend_idx_q <= 3'd0;
            pend_ts_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            strobe_q   <= strobe_d;
            gray_q     <= gray_d;
            pend_vld_q <= pend_vld_d;
            pend_idx_q <= pend_idx_d;
            pend_ts_q  <= pend_ts_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage is not reset: emptiness is tracked by count_q alone.
    always_ff @(posedge clk_master) begin
        if (do_push) begin
            fifo_mem[wr_ptr_q] <= rec_word;
        end
    end

    assign oct_strobe = strobe_q;
    assign gray_cnt   = gray_q;
    assign ovf        = ovf_q;
    // First-word-fall-through; forced to zero whenever the FIFO is empty.
    assign rec_data   = rec_valid ? fifo_mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_octave_readout_sched.sv
`timescale 1ns/1ps
module tb_octave_readout_sched;

    localparam int N     = 8;
    localparam int CW    = 10;
    localparam int DEPTH = 16;
    localparam int RW    = CW + 7;

    logic            clk_master = 1'b0;
    logic            rstb = 1'b0;
    logic            en = 1'b0;
    logic [N-1:0]    oct_mask = '0;
    logic [N-1:0]    oct_strobe;
    logic [CW-1:0]   gray_cnt;
    logic [2*N-1:0]  read_out_I_bus = '0;
    logic [2*N-1:0]  read_out_Q_bus = '0;
    logic            rec_valid;
    logic            rec_ready = 1'b0;
    logic [RW-1:0]   rec_data;
    logic            ovf;
    logic            ovf_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [RW-1:0] exp_q [$];

    octave_readout_sched #(
        .NUM_OCTAVES (N),
        .CNT_W       (CW),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_master     (clk_master),
        .rstb           (rstb),
        .en             (en),
        .oct_mask       (oct_mask),
        .oct_strobe     (oct_strobe),
        .gray_cnt       (gray_cnt),
        .read_out_I_bus (read_out_I_bus),
        .read_out_Q_bus (read_out_Q_bus),
        .rec_valid      (rec_valid),
        .rec_ready      (rec_ready),
        .rec_data       (rec_data),
        .ovf            (ovf),
        .ovf_clr        (ovf_clr)
    );

    always #5 clk_master = ~clk_master;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [CW-1:0] to_gray(input logic [CW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [CW-1:0] from_gray(input logic [CW-1:0] g);
        logic [CW-1:0] b;
        b[CW-1] = g[CW-1];
        for (int i = CW-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Ruler sequence: octave = number of trailing ones of the counter.
    function automatic logic [N-1:0] ruler_onehot(input logic [CW-1:0] c);
        logic [N-1:0] r;
        int t;
        r = '0;
        t = 0;
        while (t < CW && c[t]) t++;
        if (t < N) r[t] = 1'b1;
        return r;
    endfunction

    function automatic int onehot_index(input logic [N-1:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < N; i++) if (v[i]) idx = i;
        return idx;
    endfunction

    // Predictor: tracks the expected schedule, capture and FIFO occupancy
    // from the bench's own inputs and queues the records the host should see.
    logic [CW-1:0] m_cnt = '0;
    logic [CW-1:0] m_gray = '0;
    logic [N-1:0]  m_strobe = '0;
    logic          m_pend_vld = 1'b0;
    int            m_pend_idx = 0;
    logic [CW-1:0] m_pend_ts = '0;
    int            m_count = 0;
    logic          m_ovf = 1'b0;

    always @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            m_cnt      <= '0;
            m_gray     <= '0;
            m_strobe   <= '0;
            m_pend_vld <= 1'b0;
            m_pend_idx <= 0;
            m_pend_ts  <= '0;
            m_count    <= 0;
            m_ovf      <= 1'b0;
            exp_q.delete();
        end else begin
            automatic bit want   = m_pend_vld && oct_mask[m_pend_idx];
            automatic bit pop    = (m_count != 0) && rec_ready;
            automatic bit accept = want && ((m_count < DEPTH) || pop);
            automatic logic [RW-1:0] rec = {3'(m_pend_idx),
                                            read_out_I_bus[2*m_pend_idx +: 2],
                                            read_out_Q_bus[2*m_pend_idx +: 2],
                                            m_pend_ts};
            if (accept) exp_q.push_back(rec);
            m_count <= m_count + (accept ? 1 : 0) - (pop ? 1 : 0);
            m_ovf   <= (want && !accept) ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
            if (en) begin
                m_cnt    <= m_cnt + CW'(1);
                m_strobe <= ruler_onehot(m_cnt);
                m_gray   <= to_gray(m_cnt);
            end else begin
                m_strobe <= '0;
            end
            m_pend_vld <= |m_strobe;
            m_pend_idx <= onehot_index(m_strobe);
            m_pend_ts  <= m_gray;
        end
    end

    // Scoreboard side: compare every record the host accepts, plus flags.
    always @(negedge clk_master) begin
        if (rstb) begin
            checks++;
            if (rec_valid !== (m_count != 0)) begin
                errors++;
                $display("FAIL rec_valid: got %b want %b", rec_valid, (m_count != 0));
            end
            checks++;
            if (ovf !== m_ovf) begin
                errors++;
                $display("FAIL ovf_flag: got %b want %b", ovf, m_ovf);
            end
            if (rec_valid && rec_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL record_unexpected: got %h want none", rec_data);
                end else begin
                    automatic logic [RW-1:0] exp_rec = exp_q.pop_front();
                    if (rec_data !== exp_rec) begin
                        errors++;
                        $display("FAIL record_data: got %h want %h", rec_data, exp_rec);
                    end else begin
                        $display("rec oct=%0d I=%b Q=%b ts=%h", rec_data[RW-1 -: 3],
                                 rec_data[CW+3 -: 2], rec_data[CW+1 -: 2], rec_data[CW-1:0]);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_master);
        #1;
    endtask

    task automatic do_reset();
        step();
        rstb = 1'b0;
        repeat (3) step();
        rstb = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) step();
        @(negedge clk_master);
        checks++; if (oct_strobe !== '0) begin errors++; $display("FAIL reset_strobe: got %h want 0", oct_strobe); end
        checks++; if (gray_cnt !== '0) begin errors++; $display("FAIL reset_gray: got %h want 0", gray_cnt); end
        checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rec_valid); end
        checks++; if (rec_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", rec_data); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        $display("test_reset done");
    endtask

    task automatic test_schedule();
        int first8 [8] = '{0, 1, 0, 2, 0, 1, 0, 3};
        int idle_n = 0;
        int oct7_n = 0;
        logic [N-1:0] want_s;
        en = 1'b1; oct_mask = '1; rec_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            @(posedge clk_master);
            #1;
            read_out_I_bus = (2*N)'($urandom);
            read_out_Q_bus = (2*N)'($urandom);
            @(negedge clk_master);
            want_s = ruler_onehot(CW'(i));
            checks++;
            if (oct_strobe !== want_s) begin
                errors++; $display("FAIL sched_strobe cnt=%0d: got %h want %h", i, oct_strobe, want_s);
            end
            checks++;
            if (gray_cnt !== to_gray(CW'(i))) begin
                errors++; $display("FAIL sched_gray cnt=%0d: got %h want %h", i, gray_cnt, to_gray(CW'(i)));
            end
            if (i < 8) begin
                want_s = '0;
                want_s[first8[i]] = 1'b1;
                checks++;
                if (oct_strobe !== want_s) begin
                    errors++; $display("FAIL first8 slot %0d: got %h want %h", i, oct_strobe, want_s);
                end
            end
            if (oct_strobe == '0) idle_n++;
            if (oct_strobe[N-1]) oct7_n++;
        end
        checks++; if (idle_n != 1) begin errors++; $display("FAIL idle_count: got %0d want 1", idle_n); end
        checks++; if (oct7_n != 1) begin errors++; $display("FAIL oct7_count: got %0d want 1", oct7_n); end
        $display("test_schedule done idle=%0d oct7=%0d", idle_n, oct7_n);
    endtask

    task automatic test_capture_data();
        bit f1 = 0;
        bit f3 = 0;
        logic [RW-1:0] want1 = {3'd1, 2'b00, 2'b00, CW'(1)};
        logic [RW-1:0] want3 = {3'd3, 2'b10, 2'b01, CW'(4)};
        en = 1'b1; oct_mask = '1; rec_ready = 1'b1;
        read_out_I_bus = '0; read_out_Q_bus = '0;
        read_out_I_bus[7:6] = 2'b10;
        read_out_Q_bus[7:6] = 2'b01;
        do_reset();
        for (int c = 0; c < 30 && !f3; c++) begin
            @(negedge clk_master);
            if (rec_valid && rec_data[RW-1 -: 3] == 3'd1 && !f1) begin
                f1 = 1;
                checks++;
                if (rec_data !== want1) begin errors++; $display("FAIL capture_oct1: got %h want %h", rec_data, want1); end
            end
            if (rec_valid && rec_data[RW-1 -: 3] == 3'd3) begin
                f3 = 1;
                checks++;
                if (rec_data !== want3) begin errors++; $display("FAIL capture_oct3: got %h want %h", rec_data, want3); end
            end
        end
        checks++;
        if (!(f1 && f3)) begin errors++; $display("FAIL capture_timeout: got seen1=%0d seen3=%0d want 1 1", f1, f3); end
        $display("test_capture_data done");
    endtask

    task automatic test_overflow();
        logic [RW-1:0] want0 = {3'd0, 2'b11, 2'b11, CW'(0)};
        en = 1'b1; oct_mask = '1; rec_ready = 1'b0;
        read_out_I_bus = '1; read_out_Q_bus = '1;
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk_master);
            #1;
            ovf_clr = (e == 30);
            @(negedge clk_master);
            if (e == 18) begin
                checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_before_17th: got %b want 0", ovf); end
            end
            if (e == 19) begin
                checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_at_17th: got %b want 1", ovf); end
            end
            if (e == 31) begin
                checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b want 1", ovf); end
            end
        end
        checks++; if (rec_valid !== 1'b1) begin errors++; $display("FAIL ovf_held_valid: got %b want 1", rec_valid); end
        step();
        rec_ready = 1'b1;
        ovf_clr = 1'b1;
        @(negedge clk_master);
        checks++; if (rec_data !== want0) begin errors++; $display("FAIL drain_first: got %h want %h", rec_data, want0); end
        step();
        ovf_clr = 1'b0;
        // FIFO stays full while pushing and popping each cycle: no drop allowed.
        for (int e = 0; e < 10; e++) begin
            @(negedge clk_master);
            checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL full_push_pop_ovf: got %b want 0", ovf); end
            step();
        end
        en = 1'b0;
        repeat (30) step();
        @(negedge clk_master);
        checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", rec_valid); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL drain_missing: got %0d left want 0", exp_q.size()); end
        $display("test_overflow done");
    endtask

    task automatic test_mask();
        int n_rec = 0;
        bit have_prev = 0;
        logic [CW-1:0] prev_b = '0;
        logic [CW-1:0] cur_b;
        en = 1'b1; oct_mask = 8'h01; rec_ready = 1'b1;
        read_out_I_bus = (2*N)'($urandom); read_out_Q_bus = (2*N)'($urandom);
        do_reset();
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk_master);
            @(negedge clk_master);
            if (rec_valid) begin
                n_rec++;
                checks++;
                if (rec_data[RW-1 -: 3] !== 3'd0) begin
                    errors++; $display("FAIL mask_idx: got %0d want 0", rec_data[RW-1 -: 3]);
                end
                cur_b = from_gray(rec_data[CW-1:0]);
                if (have_prev) begin
                    checks++;
                    if (cur_b - prev_b !== CW'(2)) begin
                        errors++; $display("FAIL mask_ts_step: got %0d want 2", cur_b - prev_b);
                    end
                end
                have_prev = 1;
                prev_b = cur_b;
            end
        end
        checks++; if (n_rec != 29) begin errors++; $display("FAIL mask_count: got %0d want 29", n_rec); end
        $display("test_mask done records=%0d", n_rec);
    endtask

    task automatic test_en_pause();
        logic [CW-1:0] hold_g;
        logic [CW-1:0] next_c;
        oct_mask = '1; rec_ready = 1'b1; en = 1'b1;
        repeat (7) step();
        en = 1'b0;
        @(negedge clk_master);
        hold_g = gray_cnt;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 4) en = 1'b1;
            @(negedge clk_master);
            checks++; if (oct_strobe !== '0) begin errors++; $display("FAIL pause_strobe: got %h want 0", oct_strobe); end
            checks++; if (gray_cnt !== hold_g) begin errors++; $display("FAIL pause_gray: got %h want %h", gray_cnt, hold_g); end
        end
        @(posedge clk_master);
        @(negedge clk_master);
        next_c = from_gray(hold_g) + CW'(1);
        checks++; if (oct_strobe !== ruler_onehot(next_c)) begin errors++; $display("FAIL resume_strobe: got %h want %h", oct_strobe, ruler_onehot(next_c)); end
        checks++; if (gray_cnt !== to_gray(next_c)) begin errors++; $display("FAIL resume_gray: got %h want %h", gray_cnt, to_gray(next_c)); end
        en = 1'b0;
        repeat (6) step();
        @(negedge clk_master);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL pause_capture_lost: got %0d left want 0", exp_q.size()); end
        $display("test_en_pause done");
    endtask

    task automatic test_reset_midrun();
        bit seen = 0;
        logic [RW-1:0] want0 = {3'd0, 2'b11, 2'b11, CW'(0)};
        en = 1'b1; oct_mask = '1; rec_ready = 1'b0;
        read_out_I_bus = '1; read_out_Q_bus = '1;
        do_reset();
        repeat (25) step();
        en = 1'b0;
        repeat (4) step();
        rec_ready = 1'b1;
        repeat (11) step();
        rec_ready = 1'b0;
        @(negedge clk_master);
        checks++; if (rec_valid !== 1'b1) begin errors++; $display("FAIL midrun_valid_before: got %b want 1", rec_valid); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL midrun_ovf_before: got %b want 1", ovf); end
        #1 rstb = 1'b0;
        #1;
        checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL midrun_valid_reset: got %b want 0", rec_valid); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL midrun_ovf_reset: got %b want 0", ovf); end
        checks++; if (rec_data !== '0) begin errors++; $display("FAIL midrun_data_reset: got %h want 0", rec_data); end
        step();
        en = 1'b1; rec_ready = 1'b1;
        step();
        rstb = 1'b1;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk_master);
            if (rec_valid) begin
                seen = 1;
                checks++;
                if (rec_data !== want0) begin errors++; $display("FAIL midrun_first_rec: got %h want %h", rec_data, want0); end
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL midrun_timeout: got no record want one"); end
        en = 1'b0;
        repeat (6) step();
        $display("test_reset_midrun done");
    endtask

    initial begin
        test_reset();
        test_schedule();
        test_capture_data();
        test_overflow();
        test_mask();
        test_en_pause();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
